sample_logger_avm: RTL

- Avalon-MM write master directly upstream of the 32-bit on-chip memory slave (13-bit word address, 5120 words, byteenable).
- Accepts a 16-bit sample stream and packs two samples per 32-bit word.
- Writes packed words sequentially into the memory, in linear or circular mode, so Nios software can read captured sensor data.

---
 rtl/sample_logger_avm.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sample_logger_avm.sv
`default_nettype none
// ============================================================================
// Module   : sample_logger_avm
// Purpose  : Packs 16-bit samples two per word and writes them sequentially
//            to an Avalon-MM memory window, linear or circular.
//            Optional macro SAMPLE_LOGGER_TIMESTAMP_EN adds a cycle-count
//            header word at BASE.
// Revision : 1.0
// ============================================================================
module sample_logger_avm #(
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = 5120,
    parameter int BASE     = 0,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                circular,
    input  logic [SAMPLE_W-1:0] snk_data,
    input  logic                snk_valid,
    output logic                snk_ready,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [3:0]          avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest,
    output logic                busy,
    output logic                wrapped,
    output logic [ADDR_W-1:0]   words_written,
    output logic                done
);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LO   = 3'd1;
    localparam logic [2:0] c_HI   = 3'd2;
    localparam logic [2:0] c_WR   = 3'd3;
    localparam logic [2:0] c_FIN  = 3'd4;

    localparam logic [ADDR_W-1:0] c_BASE  = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(BASE + DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_DEPTH = ADDR_W'(DEPTH);

`ifdef SAMPLE_LOGGER_TIMESTAMP_EN
    // The header word is written before any sample is taken.
    localparam logic [2:0] c_START_ST = c_WR;

    logic [31:0] r_cycle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end
`else
    localparam logic [2:0] c_START_ST = c_LO;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [31:0]       r_data;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_words;
    logic              r_wrapped;
    logic              r_circ;
    logic              r_stop_pend;
    logic              w_ready;
    logic              w_write;
    logic              w_busy;
    logic              w_done;
    logic              w_accept;
    logic              w_at_end;

    assign w_accept = snk_valid & w_ready;
    assign w_at_end = (r_ptr == c_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) w_next = c_START_ST;
            end
            c_LO: begin
                // A sample taken together with stop leaves a half word to flush.
                if (stop) w_next = w_accept ? c_WR : c_FIN;
                else if (w_accept) w_next = c_HI;
            end
            c_HI: begin
                if (w_accept || stop) w_next = c_WR;
            end
            c_WR: begin
                if (!avm_waitrequest) begin
                    if (stop || r_stop_pend) w_next = c_FIN;
                    else if (w_at_end && !r_circ) w_next = c_FIN;
                    else w_next = c_LO;
                end
            end
            c_FIN: begin
                w_next = c_IDLE;
            end
            default: begin
                w_next = c_IDLE;
            end
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_write = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            c_LO:    begin w_ready = 1'b1; w_busy = 1'b1; end
            c_HI:    begin w_ready = 1'b1; w_busy = 1'b1; end
            c_WR:    begin w_write = 1'b1; w_busy = 1'b1; end
            c_FIN:   begin w_done  = 1'b1; end
            default: begin w_busy  = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= c_BASE;
            r_data      <= '0;
            r_be        <= '0;
            r_words     <= '0;
            r_wrapped   <= 1'b0;
            r_circ      <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_ptr       <= c_BASE;
                        r_circ      <= circular;
                        r_wrapped   <= 1'b0;
                        r_words     <= '0;
                        r_stop_pend <= 1'b0;
`ifdef SAMPLE_LOGGER_TIMESTAMP_EN
                        r_data      <= r_cycle;
                        r_be        <= 4'b1111;
`endif
                    end
                end
                c_LO: begin
                    if (w_accept) r_data[15:0] <= snk_data;
                    if (stop) begin
                        r_stop_pend   <= 1'b1;
                        r_data[31:16] <= '0;
                        r_be          <= 4'b0011;
                    end
                end
                c_HI: begin
                    if (w_accept) begin
                        r_data[31:16] <= snk_data;
                        r_be          <= 4'b1111;
                    end else if (stop) begin
                        r_data[31:16] <= '0;
                        r_be          <= 4'b0011;
                    end
                    if (stop) r_stop_pend <= 1'b1;
                end
                c_WR: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (!avm_waitrequest) begin
                        if (r_words != c_DEPTH) r_words <= r_words + 1'b1;
                        // Linear mode parks the pointer on the last word written.
                        if (w_at_end) begin
                            if (r_circ) begin
                                r_ptr     <= c_BASE;
                                r_wrapped <= 1'b1;
                            end
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                c_FIN: begin
                    r_stop_pend <= 1'b0;
                end
                default: begin
                    r_stop_pend <= 1'b0;
                end
            endcase
        end
    end

    assign snk_ready      = w_ready;
    assign avm_write      = w_write;
    assign avm_chipselect = w_write;
    assign avm_address    = r_ptr;
    assign avm_writedata  = r_data;
    assign avm_byteenable = r_be;
    assign busy           = w_busy;
    assign done           = w_done;
    assign wrapped        = r_wrapped;
    assign words_written  = r_words;

endmodule
`default_nettype wire
